// File: rtl/mem_access_pkg.sv
// ----------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the M (memory access) pipeline stage:
//   - NOP instruction word emitted on pipeline bubbles
//   - access-size codes carried in funct3[1:0] (funct3[2] selects zero-extend)
//   - FSM state encoding (2 bits) used by mem_access and exposed for debug
// ----------------------------------------------------------------------------
package mem_access_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // funct3[1:0] access size; funct3[2] = 1 means unsigned (LBU/LHU)
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } state_t;

endpackage : mem_access_pkg

// File: rtl/mem_access_if.sv
// ----------------------------------------------------------------------------
// mem_access_if
// Data-memory port used by the M stage.
//
// Handshake: the master raises req together with we/addr/wdata/wstrb and
// keeps all of them stable until the slave answers with gnt in the same
// cycle; req drops the cycle after gnt. Exactly one cycle of rvalid (with
// rdata for loads, as an ack for stores) follows each granted request, at
// any later cycle. The master ignores gnt while not requesting and rvalid
// while not waiting for a response.
//
//   req    master->slave  request valid
//   we     master->slave  1 = store
//   addr   master->slave  word-aligned byte address
//   wdata  master->slave  store data replicated across byte lanes
//   wstrb  master->slave  byte enables
//   gnt    slave->master  request accepted this cycle
//   rvalid slave->master  response this cycle
//   rdata  slave->master  load word
// ----------------------------------------------------------------------------
interface mem_access_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      wstrb;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output gnt, rvalid, rdata
  );
endinterface : mem_access_if

// File: rtl/mem_access_lsu_align.sv
// ----------------------------------------------------------------------------
// mem_access_lsu_align
// Purely combinational byte-lane logic for a 32-bit data memory.
//   funct3_i      size/sign code (B, H, W, BU, HU)
//   addr_lo_i     byte offset within the word
//   store_data_i  rs2 value for stores
//   rdata_i       word returned by memory for loads
//   wdata_o       store data replicated into every lane of its size
//   wstrb_o       byte enables for the addressed lanes
//   load_data_o   addressed lane of rdata_i, sign/zero extended
//   misalign_o    halfword on odd address or word not on a 4-byte boundary
// ----------------------------------------------------------------------------
module mem_access_lsu_align
  import mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] wdata_o,
  output logic [3:0]      wstrb_o,
  output logic [XLEN-1:0] load_data_o,
  output logic            misalign_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        unsigned_ld;

  always_comb begin
    byte_lane   = rdata_i[{addr_lo_i, 3'b000} +: 8];
    // a halfword is only ever legal at offset 0 or 2, so addr bit 1 picks it
    half_lane   = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    unsigned_ld = funct3_i[2];

    wdata_o     = store_data_i;
    wstrb_o     = 4'b1111;
    load_data_o = rdata_i;
    misalign_o  = 1'b0;

    case (funct3_i[1:0])
      SIZE_B: begin
        wdata_o     = {4{store_data_i[7:0]}};
        wstrb_o     = 4'b0001 << addr_lo_i;
        load_data_o = unsigned_ld ? {24'b0, byte_lane}
                                  : {{24{byte_lane[7]}}, byte_lane};
      end
      SIZE_H: begin
        wdata_o     = {2{store_data_i[15:0]}};
        wstrb_o     = 4'b0011 << addr_lo_i;
        load_data_o = unsigned_ld ? {16'b0, half_lane}
                                  : {{16{half_lane[15]}}, half_lane};
        misalign_o  = addr_lo_i[0];
      end
      default: begin
        // word (and any unused size code) behaves as a full-word access
        misalign_o  = |addr_lo_i;
      end
    endcase
  end

endmodule : mem_access_lsu_align

// File: rtl/mem_access.sv
// ----------------------------------------------------------------------------
// mem_access
// M stage of the pipeline. Takes the instruction leaving E, performs its
// load/store on the data-memory port and presents the result to write_back.
// Non-memory instructions pass straight through with one cycle of latency.
//
// Ports
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   E_valid_i           E holds a valid instruction
//   E_instr_i           instruction word from E
//   E_data_i            ALU result, the effective address for loads/stores
//   E_store_data_i      rs2 value for stores
//   E_mem_read_i        instruction is a load
//   E_mem_write_i       instruction is a store
//   E_funct3_i          size/sign code
//   flush_i             kill the instruction in E/M (branch redirect)
//   stall_o             hold E/D/F (combinational)
//   M_valid_o           M outputs carry a valid instruction
//   M_instr_o           instruction for write_back, NOP on a bubble
//   M_data_o            extended load data, or E_data_i
//   M_misalign_o        misaligned load/store, no access was made
//   state_o             current FSM state (debug visibility)
//   dmem                data-memory port (master side)
//
// Operation
//   IDLE -> REQ -> WAIT -> IDLE. The memory request is fully registered and
//   only driven while in REQ. E is held by stall_o for the whole access, so
//   the instruction, address and funct3 are read again from E when the
//   response arrives instead of being copied into M. A flush after the
//   request has been granted cannot cancel it; kill_q remembers that the
//   coming response has to be swallowed.
// ----------------------------------------------------------------------------
module mem_access
  import mem_access_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   E_valid_i,
  input  logic [INSTR_WIDTH-1:0] E_instr_i,
  input  logic [XLEN-1:0]        E_data_i,
  input  logic [XLEN-1:0]        E_store_data_i,
  input  logic                   E_mem_read_i,
  input  logic                   E_mem_write_i,
  input  logic [2:0]             E_funct3_i,
  input  logic                   flush_i,
  output logic                   stall_o,
  output logic                   M_valid_o,
  output logic [INSTR_WIDTH-1:0] M_instr_o,
  output logic [XLEN-1:0]        M_data_o,
  output logic                   M_misalign_o,
  output state_t                 state_o,
  mem_access_if.master           dmem
);

  // --------------------------------------------------------------------------
  // Lane alignment / extension
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] al_wdata;
  logic [3:0]      al_wstrb;
  logic [XLEN-1:0] al_load_data;
  logic            al_misalign;

  mem_access_lsu_align #(
    .XLEN (XLEN)
  ) u_lsu_align (
    .funct3_i     (E_funct3_i),
    .addr_lo_i    (E_data_i[1:0]),
    .store_data_i (E_store_data_i),
    .rdata_i      (dmem.rdata),
    .wdata_o      (al_wdata),
    .wstrb_o      (al_wstrb),
    .load_data_o  (al_load_data),
    .misalign_o   (al_misalign)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                 state_q,     state_d;
  logic                   kill_q,      kill_d;
  logic                   m_valid_q,   m_valid_d;
  logic [INSTR_WIDTH-1:0] m_instr_q,   m_instr_d;
  logic [XLEN-1:0]        m_data_q,    m_data_d;
  logic                   m_misalign_q, m_misalign_d;
  logic                   req_q,       req_d;
  logic                   we_q,        we_d;
  logic [XLEN-1:0]        addr_q,      addr_d;
  logic [XLEN-1:0]        wdata_q,     wdata_d;
  logic [3:0]             wstrb_q,     wstrb_d;

  logic mem_op;
  logic issue;

  always_comb begin
    mem_op = E_mem_read_i | E_mem_write_i;
    issue  = (state_q == ST_IDLE) & E_valid_i & mem_op & ~al_misalign & ~flush_i;

    // Upstream must hold while an access is open; the completion cycle
    // itself releases E so the next instruction can move in behind it.
    stall_o = ((state_q != ST_IDLE) & ~((state_q == ST_WAIT) & dmem.rvalid)) | issue;

    state_d      = state_q;
    kill_d       = kill_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    // M defaults to a bubble every cycle; only completions overwrite it
    m_valid_d    = 1'b0;
    m_instr_d    = INSTR_WIDTH'(NOP_INSTR);
    m_data_d     = '0;
    m_misalign_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (E_valid_i && !flush_i) begin
          if (mem_op && !al_misalign) begin
            state_d = ST_REQ;
            req_d   = 1'b1;
            we_d    = E_mem_write_i;
            addr_d  = {E_data_i[XLEN-1:2], 2'b00};
            wdata_d = al_wdata;
            wstrb_d = al_wstrb;
          end else begin
            // ALU op, or a misaligned access reported without touching memory
            m_valid_d    = 1'b1;
            m_instr_d    = E_instr_i;
            m_data_d     = E_data_i;
            m_misalign_d = mem_op;
          end
        end
      end

      ST_REQ: begin
        if (dmem.gnt || flush_i) begin
          state_d = dmem.gnt ? ST_WAIT : ST_IDLE;
          kill_d  = dmem.gnt & flush_i;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          wstrb_d = '0;
        end
      end

      ST_WAIT: begin
        if (dmem.rvalid) begin
          state_d = ST_IDLE;
          kill_d  = 1'b0;
          if (!kill_q && !flush_i) begin
            m_valid_d = 1'b1;
            m_instr_d = E_instr_i;
            m_data_d  = E_mem_read_i ? al_load_data : E_data_i;
          end
        end else if (flush_i) begin
          kill_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        kill_d  = 1'b0;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      kill_q       <= 1'b0;
      m_valid_q    <= 1'b0;
      m_instr_q    <= INSTR_WIDTH'(NOP_INSTR);
      m_data_q     <= '0;
      m_misalign_q <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      state_q      <= state_d;
      kill_q       <= kill_d;
      m_valid_q    <= m_valid_d;
      m_instr_q    <= m_instr_d;
      m_data_q     <= m_data_d;
      m_misalign_q <= m_misalign_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign M_valid_o    = m_valid_q;
  assign M_instr_o    = m_instr_q;
  assign M_data_o     = m_data_q;
  assign M_misalign_o = m_misalign_q;
  assign state_o      = state_q;

  assign dmem.req     = req_q;
  assign dmem.we      = we_q;
  assign dmem.addr    = addr_q;
  assign dmem.wdata   = wdata_q;
  assign dmem.wstrb   = wstrb_q;

endmodule : mem_access

// File: tb/tb_mem_access.sv
// ----------------------------------------------------------------------------
// tb_mem_access
// Self-checking bench for mem_access. A memory responder process answers
// requests with programmable grant and response delays. Expected M results
// are queued when an instruction is driven and popped whenever M_valid_o is
// seen. All outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_mem_access;
  import mem_access_pkg::*;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_i;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------- DUT ----------------
  logic        E_valid_i;
  logic [31:0] E_instr_i;
  logic [31:0] E_data_i;
  logic [31:0] E_store_data_i;
  logic        E_mem_read_i;
  logic        E_mem_write_i;
  logic [2:0]  E_funct3_i;
  logic        flush_i;
  logic        stall_o;
  logic        M_valid_o;
  logic [31:0] M_instr_o;
  logic [31:0] M_data_o;
  logic        M_misalign_o;
  state_t      state_o;

  mem_access_if #(.XLEN(32)) dmem_bus ();

  mem_access #(
    .XLEN        (32),
    .INSTR_WIDTH (32)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .E_valid_i      (E_valid_i),
    .E_instr_i      (E_instr_i),
    .E_data_i       (E_data_i),
    .E_store_data_i (E_store_data_i),
    .E_mem_read_i   (E_mem_read_i),
    .E_mem_write_i  (E_mem_write_i),
    .E_funct3_i     (E_funct3_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .M_valid_o      (M_valid_o),
    .M_instr_o      (M_instr_o),
    .M_data_o       (M_data_o),
    .M_misalign_o   (M_misalign_o),
    .state_o        (state_o),
    .dmem           (dmem_bus.master)
  );

  // ---------------- memory responder ----------------
  int          gnt_delay;
  int          rvalid_delay;
  logic [31:0] mem_word;
  int          inject_cnt;

  initial begin
    int req_cnt;
    int rsp_cnt;
    int inject_seen;
    req_cnt = 0;
    rsp_cnt = 0;
    inject_seen = 0;
    dmem_bus.gnt    = 1'b0;
    dmem_bus.rvalid = 1'b0;
    dmem_bus.rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      dmem_bus.gnt    = 1'b0;
      dmem_bus.rvalid = 1'b0;
      if (rst_i) begin
        req_cnt = 0;
        rsp_cnt = 0;
      end else begin
        if (rsp_cnt > 0) begin
          rsp_cnt--;
          if (rsp_cnt == 0) begin
            dmem_bus.rvalid = 1'b1;
            dmem_bus.rdata  = mem_word;
          end
        end
        if (inject_cnt != inject_seen) begin
          inject_seen     = inject_cnt;
          dmem_bus.rvalid = 1'b1;
          dmem_bus.rdata  = mem_word;
        end
        if (dmem_bus.req) begin
          if (req_cnt >= gnt_delay) begin
            dmem_bus.gnt = 1'b1;
            rsp_cnt = rvalid_delay;
            req_cnt = 0;
          end else begin
            req_cnt++;
          end
        end else begin
          req_cnt = 0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q[$];
  int          n_checks;
  int          n_fail;
  int          req_cycles;
  logic        prev_req;
  logic        prev_gnt;
  logic [68:0] prev_bus;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;
  logic        cap_we;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // called once per cycle on the falling edge
  task automatic monitor();
    logic [68:0] bus_now;
    logic [64:0] exp;
    bus_now = {dmem_bus.we, dmem_bus.addr, dmem_bus.wdata, dmem_bus.wstrb};
    if (dmem_bus.req) begin
      req_cycles++;
      if (prev_req && !prev_gnt) begin
        check("req_stable", bus_now, prev_bus);
      end else begin
        cap_we    = dmem_bus.we;
        cap_addr  = dmem_bus.addr;
        cap_wdata = dmem_bus.wdata;
        cap_wstrb = dmem_bus.wstrb;
      end
    end
    prev_req = dmem_bus.req;
    prev_gnt = dmem_bus.gnt;
    prev_bus = bus_now;
    if (M_valid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_m_valid", M_valid_o, 1'b0);
      end else begin
        exp = exp_q.pop_front();
        check("m_result", {M_misalign_o, M_instr_o, M_data_o}, exp);
      end
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'b0, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'b0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] ref_wstrb(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B:    return 4'b0001 << a;
      F3_H:    return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      F3_B:    return {4{d[7:0]}};
      F3_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic observe();
    @(negedge clk);
    monitor();
  endtask

  task automatic clear_e();
    E_valid_i      = 1'b0;
    E_mem_read_i   = 1'b0;
    E_mem_write_i  = 1'b0;
    E_instr_i      = '0;
    E_data_i       = '0;
    E_store_data_i = '0;
    E_funct3_i     = '0;
  endtask

  task automatic set_e(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] instr);
    E_valid_i      = 1'b1;
    E_mem_read_i   = rd;
    E_mem_write_i  = wr;
    E_funct3_i     = f3;
    E_data_i       = addr;
    E_store_data_i = sdata;
    E_instr_i      = instr;
  endtask

  // Drive one instruction, hold it while stall_o is high, then check M
  // produces a valid result in the cycle after E is released.
  task automatic drive_instr(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [31:0] instr, input logic [31:0] rsp_word,
                             input logic [31:0] exp_data, input logic exp_mis,
                             output int stalls);
    mem_word = rsp_word;
    next_drive();
    set_e(rd, wr, f3, addr, sdata, instr);
    exp_q.push_back({exp_mis, instr, exp_data});
    stalls = 0;
    observe();
    while (stall_o && stalls < 50) begin
      stalls++;
      next_drive();
      observe();
    end
    if (stalls >= 50) check("stall_timeout", stalls, 0);
    next_drive();
    clear_e();
    observe();
    check("m_valid_latency", M_valid_o, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          st;
    int          g;
    int          rc0;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [31:0] r_instr;
    logic [31:0] r_word;
    logic [2:0]  r_f3;
    logic        r_wr;
    logic [2:0]  load_f3_tab[5];

    load_f3_tab = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    n_checks     = 0;
    n_fail       = 0;
    req_cycles   = 0;
    prev_req     = 1'b0;
    prev_gnt     = 1'b0;
    prev_bus     = '0;
    cap_addr     = '0;
    cap_wdata    = '0;
    cap_wstrb    = '0;
    cap_we       = 1'b0;
    gnt_delay    = 0;
    rvalid_delay = 1;
    mem_word     = '0;
    inject_cnt   = 0;
    flush_i      = 1'b0;
    clear_e();

    // reset state
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    observe();
    check("rst_m_valid",  M_valid_o, 1'b0);
    check("rst_m_instr",  M_instr_o, 32'h0000_0013);
    check("rst_m_data",   M_data_o, 32'h0);
    check("rst_misalign", M_misalign_o, 1'b0);
    check("rst_req",      dmem_bus.req, 1'b0);
    check("rst_dmem_out", {dmem_bus.we, dmem_bus.addr, dmem_bus.wdata, dmem_bus.wstrb}, 69'h0);
    check("rst_stall",    stall_o, 1'b0);
    check("rst_state",    state_o, ST_IDLE);
    next_drive();
    rst_i = 1'b0;
    observe();

    // ALU pass-through, one cycle, no stall
    for (int i = 0; i < 6; i++) begin
      r_data  = $urandom();
      r_instr = $urandom();
      drive_instr(1'b0, 1'b0, 3'($urandom_range(0, 7)), r_data, $urandom(), r_instr,
                  32'h0, r_data, 1'b0, st);
      check("alu_stall", st, 0);
    end

    // directed loads, zero-wait memory
    drive_instr(1'b1, 1'b0, F3_W, 32'h100, 32'h0, 32'h0001_2003, 32'hDEAD_BEEF,
                32'hDEAD_BEEF, 1'b0, st);
    check("lw_stall_cycles", st, 2);
    check("lw_addr", cap_addr, 32'h100);
    check("lw_we", cap_we, 1'b0);
    drive_instr(1'b1, 1'b0, F3_B,  32'h103, 32'h0, 32'h0001_0003, 32'h8012_3456,
                32'hFFFF_FF80, 1'b0, st);
    check("lb_addr", cap_addr, 32'h100);
    drive_instr(1'b1, 1'b0, F3_BU, 32'h103, 32'h0, 32'h0001_4003, 32'h8012_3456,
                32'h0000_0080, 1'b0, st);
    drive_instr(1'b1, 1'b0, F3_H,  32'h102, 32'h0, 32'h0001_1003, 32'h8012_3456,
                32'hFFFF_8012, 1'b0, st);
    drive_instr(1'b1, 1'b0, F3_HU, 32'h102, 32'h0, 32'h0001_5003, 32'h8012_3456,
                32'h0000_8012, 1'b0, st);
    drive_instr(1'b1, 1'b0, F3_B,  32'h100, 32'h0, 32'h0001_0083, 32'h8012_3456,
                32'h0000_0056, 1'b0, st);

    // directed stores
    drive_instr(1'b0, 1'b1, F3_H, 32'h102, 32'h1234_ABCD, 32'h0020_1123, 32'h0,
                32'h102, 1'b0, st);
    check("sh_addr",   cap_addr, 32'h100);
    check("sh_wstrb",  cap_wstrb, 4'b1100);
    check("sh_wdata",  cap_wdata, 32'hABCD_ABCD);
    check("sh_we",     cap_we, 1'b1);
    check("sh_stalls", st, 2);
    drive_instr(1'b0, 1'b1, F3_B, 32'h101, 32'h0000_00A5, 32'h0020_0023, 32'h0,
                32'h101, 1'b0, st);
    check("sb_wstrb", cap_wstrb, 4'b0010);
    check("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    drive_instr(1'b0, 1'b1, F3_W, 32'h104, 32'h1122_3344, 32'h0020_2223, 32'h0,
                32'h104, 1'b0, st);
    check("sw_wstrb", cap_wstrb, 4'b1111);
    check("sw_wdata", cap_wdata, 32'h1122_3344);

    // misaligned: no request, one-cycle pass-through flagged
    rc0 = req_cycles;
    drive_instr(1'b1, 1'b0, F3_W, 32'h101, 32'h0, 32'h0011_2003, 32'h0,
                32'h101, 1'b1, st);
    check("mis_lw_stall", st, 0);
    drive_instr(1'b0, 1'b1, F3_H, 32'h103, 32'h5555, 32'h0011_1023, 32'h0,
                32'h103, 1'b1, st);
    check("mis_sh_stall", st, 0);
    drive_instr(1'b1, 1'b0, F3_W, 32'h102, 32'h0, 32'h0011_2083, 32'h0,
                32'h102, 1'b1, st);
    check("mis_no_req", req_cycles - rc0, 0);

    // random aligned accesses with random memory timing
    for (int i = 0; i < 10; i++) begin
      gnt_delay    = $urandom_range(0, 3);
      rvalid_delay = $urandom_range(1, 3);
      r_wr    = 1'($urandom_range(0, 1));
      r_f3    = r_wr ? 3'($urandom_range(0, 2)) : load_f3_tab[$urandom_range(0, 4)];
      r_addr  = $urandom();
      if (r_f3[1:0] == 2'b01) r_addr[0] = 1'b0;
      if (r_f3[1:0] == 2'b10) r_addr[1:0] = 2'b00;
      r_data  = $urandom();
      r_word  = $urandom();
      r_instr = $urandom();
      drive_instr(~r_wr, r_wr, r_f3, r_addr, r_data, r_instr, r_word,
                  r_wr ? r_addr : ref_load(r_f3, r_addr[1:0], r_word), 1'b0, st);
      check("rnd_stalls", st, gnt_delay + rvalid_delay + 1);
      check("rnd_addr", cap_addr, {r_addr[31:2], 2'b00});
      check("rnd_we", cap_we, r_wr);
      if (r_wr) begin
        check("rnd_wstrb", cap_wstrb, ref_wstrb(r_f3, r_addr[1:0]));
        check("rnd_wdata", cap_wdata, ref_wdata(r_f3, r_data));
      end
    end

    // grant delayed 4 cycles, flush while waiting for the response
    gnt_delay    = 4;
    rvalid_delay = 3;
    mem_word     = 32'hCAFE_F00D;
    rc0 = req_cycles;
    next_drive();
    set_e(1'b1, 1'b0, F3_W, 32'h140, 32'h0, 32'h0000_2503);
    observe();
    g = 0;
    while (state_o != ST_WAIT && g < 20) begin
      g++;
      next_drive();
      observe();
    end
    check("gd4_req_cycles", req_cycles - rc0, 5);
    check("gd4_addr", cap_addr, 32'h140);
    next_drive();
    flush_i = 1'b1;
    clear_e();
    observe();
    check("flush_wait_m_valid", M_valid_o, 1'b0);
    next_drive();
    flush_i = 1'b0;
    observe();
    g = 0;
    while (state_o != ST_IDLE && g < 20) begin
      check("kill_m_valid", M_valid_o, 1'b0);
      g++;
      next_drive();
      observe();
    end
    check("kill_back_idle", state_o, ST_IDLE);
    check("kill_m_valid_after", M_valid_o, 1'b0);

    // next access must complete normally once the kill has been consumed
    gnt_delay    = 0;
    rvalid_delay = 1;
    drive_instr(1'b1, 1'b0, F3_W, 32'h144, 32'h0, 32'h0000_2583, 32'h0BAD_F00D,
                32'h0BAD_F00D, 1'b0, st);
    check("post_kill_stalls", st, 2);

    // flush in REQ before grant: request withdrawn
    gnt_delay = 10;
    next_drive();
    set_e(1'b1, 1'b0, F3_W, 32'h180, 32'h0, 32'h0000_2603);
    observe();
    next_drive();
    observe();
    check("freq_in_req", state_o, ST_REQ);
    next_drive();
    flush_i = 1'b1;
    clear_e();
    observe();
    check("freq_req_held", dmem_bus.req, 1'b1);
    next_drive();
    flush_i = 1'b0;
    observe();
    check("freq_idle", state_o, ST_IDLE);
    check("freq_req_drop", dmem_bus.req, 1'b0);
    check("freq_m_valid", M_valid_o, 1'b0);
    check("freq_stall", stall_o, 1'b0);
    gnt_delay = 0;

    // flush in IDLE together with a memory op: nothing issued
    rc0 = req_cycles;
    next_drive();
    set_e(1'b1, 1'b0, F3_W, 32'h1C0, 32'h0, 32'h0000_2683);
    flush_i = 1'b1;
    observe();
    check("fidle_stall", stall_o, 1'b0);
    next_drive();
    flush_i = 1'b0;
    clear_e();
    observe();
    check("fidle_m_valid", M_valid_o, 1'b0);
    check("fidle_m_instr", M_instr_o, 32'h0000_0013);
    next_drive();
    observe();
    check("fidle_no_req", req_cycles - rc0, 0);

    // reset during REQ, then a stray response afterwards
    gnt_delay = 20;
    next_drive();
    set_e(1'b1, 1'b0, F3_W, 32'h200, 32'h0, 32'h0000_2703);
    observe();
    next_drive();
    observe();
    check("rst_mid_req_pre", dmem_bus.req, 1'b1);
    rst_i = 1'b1;
    clear_e();
    #1;
    check("rst_mid_req_drop", dmem_bus.req, 1'b0);
    check("rst_mid_instr", M_instr_o, 32'h0000_0013);
    check("rst_mid_state", state_o, ST_IDLE);
    next_drive();
    rst_i = 1'b0;
    gnt_delay = 0;
    observe();
    mem_word = 32'h1234_5678;
    inject_cnt++;
    next_drive();
    observe();
    check("late_rvalid_seen", dmem_bus.rvalid, 1'b1);
    check("late_rvalid_state", state_o, ST_IDLE);
    next_drive();
    observe();
    check("late_rvalid_m_valid", M_valid_o, 1'b0);
    check("late_rvalid_req", dmem_bus.req, 1'b0);

    // pipeline still works after reset
    drive_instr(1'b1, 1'b0, F3_HU, 32'h206, 32'h0, 32'h0000_5783, 32'hBEEF_0000,
                32'h0000_BEEF, 1'b0, st);

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_access
